// File: rtl/card_grid_click_decoder.sv
// Click-to-card decoder for the memory-game board: maps a left-click onto the card grid,
// filters the card through its state lookup and pairs accepted clicks into first/second selections.
module card_grid_click_decoder #(
  parameter int NUM_X   = 4,
  parameter int NUM_Y   = 3,
  parameter int X0      = 50,
  parameter int Y0      = 50,
  parameter int PITCH_X = 258,
  parameter int PITCH_Y = 234,
  parameter int CARD_W  = 150,
  parameter int CARD_H  = 200,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mouse_left,
  input  logic [11:0]       mouse_xpos,
  input  logic [11:0]       mouse_ypos,
  input  logic              clear_pair,
  output logic [ADDR_W-1:0] card_state_addr,
  input  logic [1:0]        card_state,
  output logic [ADDR_W-1:0] card_clicked_address,
  output logic              event_occurred,
  output logic [ADDR_W-1:0] first_address,
  output logic [ADDR_W-1:0] second_address,
  output logic              pair_valid,
  output logic              busy
);

  localparam int COL_W = (NUM_X > 1) ? $clog2(NUM_X) : 1;
  localparam int ROW_W = (NUM_Y > 1) ? $clog2(NUM_Y) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    LOOKUP,
    CHECK,
    EMIT
  } state_t;

  state_t state, next_state;

  logic              btn_prev;
  logic              click;
  logic [11:0]       x_q;
  logic [11:0]       y_q;
  logic              col_hit;
  logic              row_hit;
  logic [COL_W-1:0]  col_idx;
  logic [ROW_W-1:0]  row_idx;
  logic [ADDR_W-1:0] card_addr;
  logic              first_held;

  assign click = mouse_left & ~btn_prev;

  // Column/row search on the latched cursor; right/bottom card edges are exclusive.
  always_comb begin
    col_hit = 1'b0;
    col_idx = '0;
    row_hit = 1'b0;
    row_idx = '0;
    for (int c = 0; c < NUM_X; c++) begin
      if (({1'b0, x_q} >= 13'(X0 + c * PITCH_X)) &&
          ({1'b0, x_q} <  13'(X0 + c * PITCH_X + CARD_W))) begin
        col_hit = 1'b1;
        col_idx = COL_W'(c);
      end
    end
    for (int r = 0; r < NUM_Y; r++) begin
      if (({1'b0, y_q} >= 13'(Y0 + r * PITCH_Y)) &&
          ({1'b0, y_q} <  13'(Y0 + r * PITCH_Y + CARD_H))) begin
        row_hit = 1'b1;
        row_idx = ROW_W'(r);
      end
    end
  end

  assign card_addr = ADDR_W'(int'(row_idx) * NUM_X + int'(col_idx) + 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (click) next_state = DECODE;
        DECODE:  next_state = (col_hit && row_hit) ? LOOKUP : IDLE;
        LOOKUP:  next_state = CHECK;
        CHECK:   next_state = (card_state == 2'b01) ? EMIT : IDLE;
        EMIT:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are loaded on the edge into EMIT so the pulse and addresses appear together.
  // A clear_pair in the deciding cycle wins, so that click starts a new pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev             <= 1'b0;
      x_q                  <= '0;
      y_q                  <= '0;
      card_state_addr      <= '0;
      card_clicked_address <= '0;
      first_address        <= '0;
      second_address       <= '0;
      event_occurred       <= 1'b0;
      pair_valid           <= 1'b0;
      first_held           <= 1'b0;
    end else begin
      btn_prev       <= mouse_left;
      event_occurred <= 1'b0;
      pair_valid     <= 1'b0;
      if (clear_pair) begin
        first_held <= 1'b0;
      end
      if (state == IDLE && next_state == DECODE) begin
        x_q <= mouse_xpos;
        y_q <= mouse_ypos;
      end
      if (state == DECODE && next_state == LOOKUP) begin
        card_state_addr <= card_addr;
      end
      if (state == CHECK && next_state == EMIT) begin
        event_occurred       <= 1'b1;
        card_clicked_address <= card_state_addr;
        if (!first_held || clear_pair) begin
          first_address <= card_state_addr;
          first_held    <= 1'b1;
        end else if (card_state_addr != first_address) begin
          second_address <= card_state_addr;
          pair_valid     <= 1'b1;
          first_held     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_card_grid_click_decoder.sv
// Directed self-checking bench for card_grid_click_decoder with a 1-cycle-latency card-state memory model.
module tb_card_grid_click_decoder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        clear_pair;
  logic [3:0]  card_state_addr;
  logic [1:0]  card_state;
  logic [3:0]  card_clicked_address;
  logic        event_occurred;
  logic [3:0]  first_address;
  logic [3:0]  second_address;
  logic        pair_valid;
  logic        busy;

  logic [1:0]  mem [16];
  int          passed;
  int          total;

  card_grid_click_decoder dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .mouse_left           (mouse_left),
    .mouse_xpos           (mouse_xpos),
    .mouse_ypos           (mouse_ypos),
    .clear_pair           (clear_pair),
    .card_state_addr      (card_state_addr),
    .card_state           (card_state),
    .card_clicked_address (card_clicked_address),
    .event_occurred       (event_occurred),
    .first_address        (first_address),
    .second_address       (second_address),
    .pair_valid           (pair_valid),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) card_state <= mem[card_state_addr];

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // One click at (x,y), then observe 7 cycles; cycle k is sampled at the k-th falling edge after the drive.
  task automatic click_watch(input logic [11:0] x, input logic [11:0] y, input logic hold_clear,
                             output int ev_at, output int ev_cnt, output int pv_at,
                             output int idle_at, output logic [3:0] cca);
    @(negedge clk);
    mouse_xpos = x;
    mouse_ypos = y;
    mouse_left = 1'b1;
    clear_pair = hold_clear;
    ev_at = -1; ev_cnt = 0; pv_at = -1; idle_at = -1; cca = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      mouse_left = 1'b0;
      if (event_occurred === 1'b1) begin
        ev_cnt++;
        if (ev_at < 0) begin ev_at = k; cca = card_clicked_address; end
      end
      if (pair_valid === 1'b1 && pv_at < 0) pv_at = k;
      if (busy === 1'b0 && idle_at < 0) idle_at = k;
    end
    clear_pair = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_pair = 1'b1;
    @(negedge clk); clear_pair = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mouse_left = 1'b0; clear_pair = 1'b0;
    mouse_xpos = '0; mouse_ypos = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (event_occurred !== 1'b0) $display("[TB] FAIL reset_event: got %b want 0", event_occurred); else passed++;
    total++; if (pair_valid !== 1'b0) $display("[TB] FAIL reset_pair_valid: got %b want 0", pair_valid); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (card_state_addr !== 4'd0) $display("[TB] FAIL reset_lookup_addr: got %0d want 0", card_state_addr); else passed++;
    total++; if (card_clicked_address !== 4'd0) $display("[TB] FAIL reset_clicked: got %0d want 0", card_clicked_address); else passed++;
    total++; if (first_address !== 4'd0) $display("[TB] FAIL reset_first: got %0d want 0", first_address); else passed++;
    total++; if (second_address !== 4'd0) $display("[TB] FAIL reset_second: got %0d want 0", second_address); else passed++;
    enable = 1'b1;
  endtask

  task automatic test_single_card();
    int ev_at, ev_cnt, pv_at, idle_at;
    logic [3:0] cca;
    click_watch(12'd50, 12'd50, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (ev_at !== 4) $display("[TB] FAIL single_latency: got %0d want 4", ev_at); else passed++;
    total++; if (ev_cnt !== 1) $display("[TB] FAIL single_pulse_count: got %0d want 1", ev_cnt); else passed++;
    total++; if (pv_at !== -1) $display("[TB] FAIL single_no_pair: got %0d want -1", pv_at); else passed++;
    total++; if (cca !== 4'd1) $display("[TB] FAIL single_clicked: got %0d want 1", cca); else passed++;
    total++; if (first_address !== 4'd1) $display("[TB] FAIL single_first: got %0d want 1", first_address); else passed++;
    total++; if (idle_at !== 5) $display("[TB] FAIL single_idle: got %0d want 5", idle_at); else passed++;
  endtask

  task automatic test_misses();
    logic [11:0] xs [3];
    logic [11:0] ys [3];
    int ev_at, ev_cnt, pv_at, idle_at;
    logic [3:0] cca;
    xs[0] = 12'd200;  ys[0] = 12'd50;
    xs[1] = 12'd1020; ys[1] = 12'd50;
    xs[2] = 12'd50;   ys[2] = 12'd250;
    for (int i = 0; i < 3; i++) begin
      click_watch(xs[i], ys[i], 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
      total++; if (ev_cnt !== 0) $display("[TB] FAIL miss%0d_event: got %0d want 0", i, ev_cnt); else passed++;
      total++; if (idle_at !== 2) $display("[TB] FAIL miss%0d_idle: got %0d want 2", i, idle_at); else passed++;
      total++; if (card_state_addr !== 4'd1) $display("[TB] FAIL miss%0d_no_lookup: got %0d want 1", i, card_state_addr); else passed++;
    end
  endtask

  task automatic test_state_filter();
    logic [1:0] bad [2];
    int ev_at, ev_cnt, pv_at, idle_at;
    logic [3:0] cca;
    bad[0] = 2'b11; bad[1] = 2'b00;
    mem[11] = 2'b01;
    click_watch(12'd566, 12'd518, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (ev_at !== 4) $display("[TB] FAIL card11_latency: got %0d want 4", ev_at); else passed++;
    total++; if (cca !== 4'd11) $display("[TB] FAIL card11_clicked: got %0d want 11", cca); else passed++;
    total++; if (pv_at !== 4) $display("[TB] FAIL card11_pair: got %0d want 4", pv_at); else passed++;
    total++; if (second_address !== 4'd11) $display("[TB] FAIL card11_second: got %0d want 11", second_address); else passed++;
    for (int i = 0; i < 2; i++) begin
      mem[11] = bad[i];
      click_watch(12'd566, 12'd518, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
      total++; if (ev_cnt !== 0) $display("[TB] FAIL reject%0d_event: got %0d want 0", i, ev_cnt); else passed++;
      total++; if (idle_at !== 4) $display("[TB] FAIL reject%0d_idle: got %0d want 4", i, idle_at); else passed++;
      total++; if (card_state_addr !== 4'd11) $display("[TB] FAIL reject%0d_lookup: got %0d want 11", i, card_state_addr); else passed++;
    end
    mem[11] = 2'b01;
    click_watch(12'd199, 12'd249, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (ev_at !== 4) $display("[TB] FAIL corner_event: got %0d want 4", ev_at); else passed++;
    total++; if (cca !== 4'd1) $display("[TB] FAIL corner_clicked: got %0d want 1", cca); else passed++;
    total++; if (first_address !== 4'd1) $display("[TB] FAIL corner_first: got %0d want 1", first_address); else passed++;
  endtask

  task automatic test_pair_sequence();
    int ev_at, ev_cnt, pv_at, idle_at;
    logic [3:0] cca;
    pulse_clear();
    for (int i = 0; i < 2; i++) begin
      click_watch(12'd566, 12'd50, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
      total++; if (ev_at !== 4) $display("[TB] FAIL card3_%0d_event: got %0d want 4", i, ev_at); else passed++;
      total++; if (pv_at !== -1) $display("[TB] FAIL card3_%0d_pair: got %0d want -1", i, pv_at); else passed++;
      total++; if (first_address !== 4'd3) $display("[TB] FAIL card3_%0d_first: got %0d want 3", i, first_address); else passed++;
    end
    click_watch(12'd566, 12'd284, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (pv_at !== 4) $display("[TB] FAIL card7_pair: got %0d want 4", pv_at); else passed++;
    total++; if (cca !== 4'd7) $display("[TB] FAIL card7_clicked: got %0d want 7", cca); else passed++;
    total++; if (first_address !== 4'd3) $display("[TB] FAIL card7_first: got %0d want 3", first_address); else passed++;
    total++; if (second_address !== 4'd7) $display("[TB] FAIL card7_second: got %0d want 7", second_address); else passed++;
  endtask

  task automatic test_held_button();
    int ev_cnt;
    ev_cnt = 0;
    @(negedge clk);
    mouse_xpos = 12'd50; mouse_ypos = 12'd50; mouse_left = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 20) mouse_left = 1'b0;
      if (event_occurred === 1'b1) ev_cnt++;
    end
    total++; if (ev_cnt !== 1) $display("[TB] FAIL held_events: got %0d want 1", ev_cnt); else passed++;
    total++; if (first_address !== 4'd1) $display("[TB] FAIL held_first: got %0d want 1", first_address); else passed++;
  endtask

  task automatic test_enable_abort();
    int ev_cnt;
    ev_cnt = 0;
    @(negedge clk);
    mouse_xpos = 12'd308; mouse_ypos = 12'd284; mouse_left = 1'b1;
    @(negedge clk); mouse_left = 1'b0;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("[TB] FAIL abort_idle: got %b want 0", busy); else passed++;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (event_occurred === 1'b1) ev_cnt++;
    end
    total++; if (ev_cnt !== 0) $display("[TB] FAIL abort_event: got %0d want 0", ev_cnt); else passed++;
    total++; if (first_address !== 4'd1) $display("[TB] FAIL abort_first_kept: got %0d want 1", first_address); else passed++;
    total++; if (card_state_addr !== 4'd6) $display("[TB] FAIL abort_lookup: got %0d want 6", card_state_addr); else passed++;
  endtask

  task automatic test_clear_pair();
    int ev_at, ev_cnt, pv_at, idle_at;
    logic [3:0] cca;
    pulse_clear();
    click_watch(12'd50, 12'd284, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (first_address !== 4'd5) $display("[TB] FAIL clear_first5: got %0d want 5", first_address); else passed++;
    pulse_clear();
    click_watch(12'd308, 12'd284, 1'b0, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (pv_at !== -1) $display("[TB] FAIL clear_no_pair: got %0d want -1", pv_at); else passed++;
    total++; if (ev_at !== 4) $display("[TB] FAIL clear_event6: got %0d want 4", ev_at); else passed++;
    total++; if (first_address !== 4'd6) $display("[TB] FAIL clear_first6: got %0d want 6", first_address); else passed++;
    click_watch(12'd566, 12'd284, 1'b1, ev_at, ev_cnt, pv_at, idle_at, cca);
    total++; if (ev_at !== 4) $display("[TB] FAIL prio_event: got %0d want 4", ev_at); else passed++;
    total++; if (pv_at !== -1) $display("[TB] FAIL prio_no_pair: got %0d want -1", pv_at); else passed++;
    total++; if (first_address !== 4'd7) $display("[TB] FAIL prio_first7: got %0d want 7", first_address); else passed++;
  endtask

  task automatic test_back_to_back();
    int ev_cnt;
    logic [3:0] cca4, cca9;
    logic pv4, pv9;
    ev_cnt = 0; cca4 = '0; cca9 = '0; pv4 = 1'b0; pv9 = 1'b0;
    pulse_clear();
    @(negedge clk);
    mouse_xpos = 12'd50; mouse_ypos = 12'd50; mouse_left = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      case (k)
        1, 3, 6: mouse_left = 1'b0;
        2: begin mouse_xpos = 12'd566; mouse_ypos = 12'd518; mouse_left = 1'b1; end
        5: begin mouse_xpos = 12'd308; mouse_ypos = 12'd50;  mouse_left = 1'b1; end
        default: ;
      endcase
      if (event_occurred === 1'b1) ev_cnt++;
      if (k == 4) begin cca4 = card_clicked_address; pv4 = pair_valid; end
      if (k == 9) begin cca9 = card_clicked_address; pv9 = pair_valid; end
    end
    total++; if (ev_cnt !== 2) $display("[TB] FAIL b2b_events: got %0d want 2", ev_cnt); else passed++;
    total++; if (cca4 !== 4'd1) $display("[TB] FAIL b2b_first_clicked: got %0d want 1", cca4); else passed++;
    total++; if (pv4 !== 1'b0) $display("[TB] FAIL b2b_first_pair: got %b want 0", pv4); else passed++;
    total++; if (cca9 !== 4'd2) $display("[TB] FAIL b2b_second_clicked: got %0d want 2", cca9); else passed++;
    total++; if (pv9 !== 1'b1) $display("[TB] FAIL b2b_second_pair: got %b want 1", pv9); else passed++;
    total++; if (second_address !== 4'd2) $display("[TB] FAIL b2b_second_addr: got %0d want 2", second_address); else passed++;
  endtask

  task automatic test_reset_mid();
    int ev_cnt;
    ev_cnt = 0;
    @(negedge clk);
    mouse_xpos = 12'd50; mouse_ypos = 12'd50; mouse_left = 1'b1;
    @(negedge clk); mouse_left = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b want 0", busy); else passed++;
    total++; if (first_address !== 4'd0) $display("[TB] FAIL rstmid_first: got %0d want 0", first_address); else passed++;
    total++; if (card_state_addr !== 4'd0) $display("[TB] FAIL rstmid_lookup: got %0d want 0", card_state_addr); else passed++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (event_occurred === 1'b1) ev_cnt++;
    end
    total++; if (ev_cnt !== 0) $display("[TB] FAIL rstmid_event: got %0d want 0", ev_cnt); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 2'b01;
    test_reset();
    test_single_card();
    test_misses();
    test_state_filter();
    test_pair_sequence();
    test_held_button();
    test_enable_abort();
    test_clear_pair();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
